i2c_frame_decoder: RTL

I2C_FRAME_DECODER -- requirements
Module: i2c_frame_decoder

---
 rtl/i2c_analyzer_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 44 ++++
 rtl/i2c_frame_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/i2c_analyzer_pkg.sv
// Shared constants for the I2C frame decoder: FSM encoding, the bit slot
// that carries ACK/NACK, and the ceiling of the per-transaction byte index.
package i2c_analyzer_pkg;

   // Decoder FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // Bit slots 0..7 carry data (MSB first); slot 8 carries ACK/NACK
   localparam logic [3:0] ACK_SLOT = 4'd8;

   // byte_index stops counting here instead of wrapping
   localparam logic [5:0] BYTE_IDX_MAX = 6'd63;

   // Saturating increment for the byte index
   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == BYTE_IDX_MAX) ? v : v + 6'd1;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Brings one raw open-drain bus line into the clk domain with a 2-FF
// synchronizer, then suppresses glitches: the filtered output only follows
// the synchronized line after FILTER_LEN consecutive samples disagree with it.
// Everything resets high so an idle bus looks idle straight out of reset.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_line_f
);

   localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_filt;
   logic [3:0] r_cnt;

   // Synchronize, then count consecutive samples differing from the filtered value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_filt  <= 1'b1;
         r_cnt   <= 4'd0;
      end else begin
         r_sync1 <= i_line;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_filt) begin
            r_cnt <= 4'd0;
         end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_sync2;
            r_cnt  <= 4'd0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   assign o_line_f = r_filt;

endmodule

// File: rtl/i2c_frame_decoder.sv
// Passive I2C bus decoder. Detects START/STOP on the filtered lines, shifts in
// 9-bit byte+ACK slots on SCL rising edges, and reports each completed byte
// together with the latched address, R/W bit and a saturating byte index.
module i2c_frame_decoder
   import i2c_analyzer_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       start_det,
   output logic       stop_det,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_ack,
   output logic       byte_is_addr,
   output logic [6:0] addr_out,
   output logic       rw_bit,
   output logic [5:0] byte_index,
   output logic       bus_busy,
   output logic       frame_err
);

   logic w_scl_f;
   logic w_sda_f;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk      (clk),
      .reset    (reset),
      .i_line   (scl_in),
      .o_line_f (w_scl_f)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk      (clk),
      .reset    (reset),
      .i_line   (sda_in),
      .o_line_f (w_sda_f)
   );

   logic       r_scl_prev;
   logic       r_sda_prev;
   logic [1:0] r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;

   logic       r_start_det;
   logic       r_stop_det;
   logic       r_byte_valid;
   logic [7:0] r_byte_data;
   logic       r_byte_ack;
   logic       r_byte_is_addr;
   logic [6:0] r_addr;
   logic       r_rw;
   logic [5:0] r_byte_index;
   logic       r_bus_busy;
   logic       r_frame_err;

   logic w_start;
   logic w_stop;
   logic w_scl_rise;
   logic w_slot_done;

   // START/STOP need SCL stable high across the SDA transition
   assign w_start    = r_scl_prev & w_scl_f & r_sda_prev & ~w_sda_f;
   assign w_stop     = r_scl_prev & w_scl_f & ~r_sda_prev & w_sda_f;
   assign w_scl_rise = ~r_scl_prev & w_scl_f;
   // The ACK slot closes a byte; bus conditions win over sampling
   assign w_slot_done = w_scl_rise & ~w_start & ~w_stop &
                        (r_state != ST_IDLE) & (r_bit_cnt == ACK_SLOT);

   // Previous-cycle copies of the filtered lines for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_prev <= w_scl_f;
         r_sda_prev <= w_sda_f;
      end
   end

   // Frame FSM, bit counter and data shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
      end else if (w_start) begin
         r_state   <= ST_ADDR;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
      end else if (w_stop) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
      end else if (w_scl_rise && (r_state != ST_IDLE)) begin
         if (r_bit_cnt == ACK_SLOT) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            if (r_state == ST_ADDR) begin
               r_state <= ST_DATA;
            end
         end else begin
            r_shift   <= {r_shift[6:0], w_sda_f};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end
   end

   // Registered event pulses and per-byte / per-transaction results
   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_det    <= 1'b0;
         r_stop_det     <= 1'b0;
         r_byte_valid   <= 1'b0;
         r_byte_data    <= 8'd0;
         r_byte_ack     <= 1'b0;
         r_byte_is_addr <= 1'b0;
         r_addr         <= 7'd0;
         r_rw           <= 1'b0;
         r_byte_index   <= 6'd0;
         r_bus_busy     <= 1'b0;
         r_frame_err    <= 1'b0;
      end else begin
         r_start_det  <= w_start;
         r_stop_det   <= w_stop;
         r_frame_err  <= (w_start | w_stop) & (r_bit_cnt != 4'd0);
         r_byte_valid <= w_slot_done;
         if (w_start) begin
            r_bus_busy   <= 1'b1;
            r_byte_index <= 6'd0;
         end else if (w_stop) begin
            r_bus_busy <= 1'b0;
         end
         if (w_slot_done) begin
            r_byte_data    <= r_shift;
            r_byte_ack     <= ~w_sda_f;
            r_byte_is_addr <= (r_state == ST_ADDR);
            r_byte_index   <= sat_inc(r_byte_index);
            if (r_state == ST_ADDR) begin
               r_addr <= r_shift[7:1];
               r_rw   <= r_shift[0];
            end
         end
      end
   end

   assign start_det    = r_start_det;
   assign stop_det     = r_stop_det;
   assign byte_valid   = r_byte_valid;
   assign byte_data    = r_byte_data;
   assign byte_ack     = r_byte_ack;
   assign byte_is_addr = r_byte_is_addr;
   assign addr_out     = r_addr;
   assign rw_bit       = r_rw;
   assign byte_index   = r_byte_index;
   assign bus_busy     = r_bus_busy;
   assign frame_err    = r_frame_err;

endmodule
